// File: rtl/mdr_mem_if_pkg.sv
// Shared definitions for the MAR/MDR memory-interface stage: default widths
// and the handshake FSM state encoding.
package mdr_mem_if_pkg;

  localparam int MIF_DATA_W = 32;
  localparam int MIF_ADDR_W = 9;

  typedef enum logic [1:0] {
    MIF_IDLE    = 2'd0,
    MIF_RD_WAIT = 2'd1,
    MIF_WR_WAIT = 2'd2
  } mifState_e;

endpackage

// File: rtl/mdr_mem_if_mdr_reg.sv
// Memory data register: clearable, load-enabled, with the source chosen
// between the datapath bus and the memory read data.
module mdr_reg
  import mdr_mem_if_pkg::*;
#(
  parameter int DATA_W = MIF_DATA_W
) (
  input  logic              clock_i,
  input  logic              clear_i,
  input  logic              loadEn_i,
  input  logic              selMem_i,
  input  logic [DATA_W-1:0] busData_i,
  input  logic [DATA_W-1:0] memData_i,
  output logic [DATA_W-1:0] mdr_o
);

  logic [DATA_W-1:0] mdr_q, mdr_d;

  always_comb begin
    mdr_d = mdr_q;
    if (loadEn_i) begin
      mdr_d = selMem_i ? memData_i : busData_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      mdr_q <= '0;
    end else begin
      mdr_q <= mdr_d;
    end
  end

  assign mdr_o = mdr_q;

endmodule

// File: rtl/mdr_mem_if.sv
// Memory-interface stage: owns MAR and MDR and runs a req/ack handshake with
// word memory, with a bounded wait and busy/done/err status for control.
module mdr_mem_if
  import mdr_mem_if_pkg::*;
#(
  parameter int DATA_W   = MIF_DATA_W,
  parameter int ADDR_W   = MIF_ADDR_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] BusMuxIn_MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  mifState_e         state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rdReq_q, wrReq_q, busy_q;
  logic              mdrLoad, mdrSelMem;
  logic [DATA_W-1:0] mdrValue;

  mdr_reg #(.DATA_W(DATA_W)) u_mdr (
    .clock_i   (clock),
    .clear_i   (clear),
    .loadEn_i  (mdrLoad),
    .selMem_i  (mdrSelMem),
    .busData_i (BusMuxOut),
    .memData_i (mem_rdata),
    .mdr_o     (mdrValue)
  );

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    waitCnt_d = waitCnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mdrLoad   = 1'b0;
    mdrSelMem = 1'b0;
    case (state_q)
      MIF_IDLE: begin
        if (MARin) begin
          mar_d = BusMuxOut[ADDR_W-1:0];
        end
        if (MDRin && !Read) begin
          mdrLoad = 1'b1;
        end
        // A conflicting Read&Write starts nothing and only reports an error.
        if (Read && Write) begin
          err_d = 1'b1;
        end else if (MDRin && Read) begin
          state_d   = MIF_RD_WAIT;
          waitCnt_d = '0;
        end else if (Write) begin
          state_d   = MIF_WR_WAIT;
          waitCnt_d = '0;
        end
      end
      MIF_RD_WAIT, MIF_WR_WAIT: begin
        if (mem_ack) begin
          mdrLoad   = (state_q == MIF_RD_WAIT);
          mdrSelMem = 1'b1;
          state_d   = MIF_IDLE;
          done_d    = 1'b1;
        end else if (waitCnt_q == LAST_WAIT) begin
          state_d = MIF_IDLE;
          err_d   = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = MIF_IDLE;
      end
    endcase
  end

  // Request and busy flags are registered from the next state so they line
  // up with the state register and never depend combinationally on inputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= MIF_IDLE;
      mar_q     <= '0;
      waitCnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdReq_q   <= 1'b0;
      wrReq_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      waitCnt_q <= waitCnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdReq_q   <= (state_d == MIF_RD_WAIT);
      wrReq_q   <= (state_d == MIF_WR_WAIT);
      busy_q    <= (state_d != MIF_IDLE);
    end
  end

  assign BusMuxIn_MDR = mdrValue;
  assign mem_wdata    = mdrValue;
  assign mem_addr     = mar_q;
  assign mem_rd_req   = rdReq_q;
  assign mem_wr_req   = wrReq_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed testbench for mdr_mem_if: reset, bus loads, read/write handshakes,
// timeout, command conflict and clear during an access.
module tb_mdr_mem_if;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic [31:0] BusMuxIn_MDR;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy, done, err;

  int checkCount = 0;
  int errorCount = 0;
  int reqCycles;

  mdr_mem_if dut (
    .clock        (clock),
    .clear        (clear),
    .BusMuxOut    (BusMuxOut),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .Read         (Read),
    .Write        (Write),
    .BusMuxIn_MDR (BusMuxIn_MDR),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd_req   (mem_rd_req),
    .mem_wr_req   (mem_wr_req),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clock = ~clock;

  // One rising edge, then return at the falling edge where outputs are sampled.
  task automatic applyStimulus();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    // Reset with garbage on every input
    clear = 1'b1; BusMuxOut = $urandom; MARin = 1'b1; MDRin = 1'b1;
    Read = 1'b1; Write = 1'b0; mem_rdata = $urandom; mem_ack = 1'b1;
    applyStimulus();
    checkOutput("reset_mdr", BusMuxIn_MDR, 32'h0);
    checkOutput("reset_wdata", mem_wdata, 32'h0);
    checkOutput("reset_addr", {23'b0, mem_addr}, 32'h0);
    checkOutput("reset_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'h0);

    clear = 1'b0; idleInputs();
    BusMuxOut = 32'hDEADBEEF; MDRin = 1'b1;
    applyStimulus();
    idleInputs();
    checkOutput("bus_load_mdr", BusMuxIn_MDR, 32'hDEADBEEF);
    checkOutput("bus_load_wdata", mem_wdata, 32'hDEADBEEF);

    BusMuxOut = 32'h0000_01A5; MARin = 1'b1;
    applyStimulus();
    idleInputs();
    checkOutput("bus_load_mar", {23'b0, mem_addr}, 32'h1A5);

    // Read without MDRin is ignored; ack while idle is ignored
    Read = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    applyStimulus();
    idleInputs();
    checkOutput("read_no_mdrin_busy", {31'b0, busy}, 32'h0);
    checkOutput("idle_ack_mdr", BusMuxIn_MDR, 32'hDEADBEEF);

    // Read with two wait states; MAR loaded in the start cycle
    BusMuxOut = 32'h0000_0010; MARin = 1'b1; MDRin = 1'b1; Read = 1'b1;
    applyStimulus();
    idleInputs();
    checkOutput("rd_c1_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b10100);
    checkOutput("rd_c1_addr", {23'b0, mem_addr}, 32'h010);
    applyStimulus();
    checkOutput("rd_c2_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b10100);
    applyStimulus();
    checkOutput("rd_c3_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b10100);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    applyStimulus();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checkOutput("rd_done_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00010);
    checkOutput("rd_mdr", BusMuxIn_MDR, 32'h12345678);
    applyStimulus();
    checkOutput("rd_after_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00000);

    // Write with zero waits; MARin/MDRin while busy must be ignored
    BusMuxOut = 32'hA5A5_0F0F; MDRin = 1'b1;
    applyStimulus();
    idleInputs();
    BusMuxOut = 32'h0000_01FF; MARin = 1'b1;
    applyStimulus();
    idleInputs();
    Write = 1'b1;
    applyStimulus();
    idleInputs();
    checkOutput("wr_c1_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b01100);
    checkOutput("wr_c1_addr", {23'b0, mem_addr}, 32'h1FF);
    checkOutput("wr_c1_wdata", mem_wdata, 32'hA5A50F0F);
    BusMuxOut = 32'h0001_2345; MARin = 1'b1; MDRin = 1'b1; mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    applyStimulus();
    idleInputs();
    checkOutput("wr_done_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00010);
    checkOutput("wr_busy_mar_ignored", {23'b0, mem_addr}, 32'h1FF);
    checkOutput("wr_busy_mdr_ignored", mem_wdata, 32'hA5A50F0F);
    applyStimulus();
    checkOutput("wr_after_done", {31'b0, done}, 32'h0);

    // Timeout: no ack at all
    MDRin = 1'b1; Read = 1'b1;
    applyStimulus();
    idleInputs();
    reqCycles = 0;
    while (mem_rd_req && reqCycles < 40) begin
      reqCycles++;
      applyStimulus();
    end
    checkOutput("timeout_req_cycles", reqCycles, 32'd15);
    checkOutput("timeout_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00001);
    checkOutput("timeout_mdr", BusMuxIn_MDR, 32'hA5A50F0F);
    applyStimulus();
    checkOutput("timeout_err_pulse", {31'b0, err}, 32'h0);

    // Read and Write together: error, no request
    MDRin = 1'b1; Read = 1'b1; Write = 1'b1; BusMuxOut = 32'h7777_7777;
    applyStimulus();
    idleInputs();
    checkOutput("conflict_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00001);
    checkOutput("conflict_mdr", BusMuxIn_MDR, 32'hA5A50F0F);
    applyStimulus();
    checkOutput("conflict_after", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00000);

    // Zero-wait read, then a new MDR load accepted in the done cycle
    MDRin = 1'b1; Read = 1'b1;
    applyStimulus();
    idleInputs();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    applyStimulus();
    idleInputs();
    checkOutput("rd0_done_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00010);
    checkOutput("rd0_mdr", BusMuxIn_MDR, 32'hCAFEF00D);
    BusMuxOut = 32'h1111_1111; MDRin = 1'b1;
    applyStimulus();
    idleInputs();
    checkOutput("load_in_done_cycle", BusMuxIn_MDR, 32'h11111111);

    // Clear in the middle of a read; a late ack afterwards is ignored
    MDRin = 1'b1; Read = 1'b1;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("clr_pre_busy", {31'b0, busy}, 32'h1);
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    checkOutput("clr_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00000);
    checkOutput("clr_mdr", BusMuxIn_MDR, 32'h0);
    checkOutput("clr_mar", {23'b0, mem_addr}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    applyStimulus();
    idleInputs();
    checkOutput("late_ack_mdr", BusMuxIn_MDR, 32'h0);
    checkOutput("late_ack_flags", {27'b0, mem_rd_req, mem_wr_req, busy, done, err}, 32'b00000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
